divider: RTL and testbench

Sequential restoring divider: the inverse of the shift-add multiplier in the execute stage. It produces quotient and remainder of two WIDTH-bit operands, signed or unsigned, one quotient bit per clock. It uses the same start/ready/done handshake as the multiplier, so the pipeline stalls on both units identically.

---
 rtl/div_pkg.sv | 32 +++
 rtl/divider_if.sv | 31 +++
 rtl/div_controller.sv | 80 ++++++++
 rtl/divider.sv | 116 +++++++++++
 tb/tb_divider.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg : shared state encoding and magnitude helper for the divider
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package div_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Magnitude of the low w bits of v; upper bits of the result are zero.
  function automatic logic [MAX_W-1:0] twos_mag(input logic [MAX_W-1:0] v,
                                                 input int unsigned    w,
                                                 input logic           is_signed);
    logic [MAX_W-1:0] mask;
    mask = {MAX_W{1'b1}} >> (MAX_W - w);
    if (is_signed && v[w-1])
      twos_mag = (~v + 1'b1) & mask;
    else
      twos_mag = v & mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/divider_if.sv
// ---------------------------------------------------------------------------
// divider_if : start/ready/done request and result bundle of the divider
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface divider_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             d_signed;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             ready;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, d_signed, src_a, src_b,
    input  ready, done, div_zero, quotient, remainder
  );

  modport slave (
    input  start, d_signed, src_a, src_b,
    output ready, done, div_zero, quotient, remainder
  );
endinterface

`default_nettype wire

// File: rtl/div_controller.sv
// ---------------------------------------------------------------------------
// div_controller : divider sequencing FSM and iteration counter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module div_controller
  import div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  wire  clk,
  input  wire  reset,
  input  wire  start,
  input  wire  b_zero,
  output logic load,
  output logic step,
  output logic fix,
  output logic load_zero,
  output logic ready,
  output logic done
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            cnt_last;

  assign cnt_last = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    step      = 1'b0;
    fix       = 1'b0;
    load_zero = 1'b0;
    ready     = (state_q == IDLE) || (state_q == DONE);
    done      = (state_q == DONE);
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (b_zero) begin
            load_zero = 1'b1;
            state_d   = DONE;
          end else begin
            load    = 1'b1;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        step  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_last)
          state_d = FIX;
      end
      FIX: begin
        fix     = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/divider.sv
// ---------------------------------------------------------------------------
// divider : sequential restoring divider, signed/unsigned, one bit per clock
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module divider
  import div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  wire       clk,
  input  wire       reset,
  divider_if.slave  bus
);

  logic load, step, fix, load_zero;
  logic b_zero;

  logic [WIDTH-1:0] a_q, a_d;          // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;

  logic [MAX_W-1:0] mag_a, mag_b;
  logic [WIDTH:0]   shifted, diff;
  logic             unused_bits;

  assign b_zero = (bus.src_b == '0);
  assign mag_a  = twos_mag({{(MAX_W-WIDTH){1'b0}}, bus.src_a}, WIDTH, bus.d_signed);
  assign mag_b  = twos_mag({{(MAX_W-WIDTH){1'b0}}, bus.src_b}, WIDTH, bus.d_signed);
  assign unused_bits = ^{mag_a[MAX_W-1:WIDTH], mag_b[MAX_W-1:WIDTH], rem_q[WIDTH]};

  assign shifted = {rem_q[WIDTH-1:0], a_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, b_q};

  div_controller #(.WIDTH(WIDTH)) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .start     (bus.start),
    .b_zero    (b_zero),
    .load      (load),
    .step      (step),
    .fix       (fix),
    .load_zero (load_zero),
    .ready     (bus.ready),
    .done      (bus.done)
  );

  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    rem_d       = rem_q;
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    if (load) begin
      a_d     = mag_a[WIDTH-1:0];
      b_d     = mag_b[WIDTH-1:0];
      rem_d   = '0;
      neg_q_d = bus.d_signed & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
      neg_r_d = bus.d_signed & bus.src_a[WIDTH-1];
    end else if (load_zero) begin
      quotient_d  = '1;
      remainder_d = bus.src_a;
      div_zero_d  = 1'b1;
    end else if (step) begin
      if (shifted >= {1'b0, b_q}) begin
        rem_d = diff;
        a_d   = {a_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = shifted;
        a_d   = {a_q[WIDTH-2:0], 1'b0};
      end
    end else if (fix) begin
      quotient_d  = neg_q_q ? (~a_q + 1'b1) : a_q;
      remainder_d = neg_r_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
      div_zero_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q         <= '0;
      b_q         <= '0;
      rem_q       <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      rem_q       <= rem_d;
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.div_zero  = div_zero_q;

endmodule

`default_nettype wire

// File: tb/tb_divider.sv
// ---------------------------------------------------------------------------
// tb_divider : directed self-checking bench for the restoring divider
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_divider;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  divider_if #(.WIDTH(4)) bus ();

  divider #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operation during one cycle t; returns in cycle t+1.
  task automatic do_start(input logic [3:0] a, input logic [3:0] b, input logic s);
    bus.src_a    = a;
    bus.src_b    = b;
    bus.d_signed = s;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.ready); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz: got %b expected 0", bus.div_zero); end
    checks++; if (bus.quotient !== 4'h0) begin errors++; $display("FAIL reset_q: got %h expected 0", bus.quotient); end
    checks++; if (bus.remainder !== 4'h0) begin errors++; $display("FAIL reset_r: got %h expected 0", bus.remainder); end
  endtask

  task automatic test_unsigned();
    do_start(4'd13, 4'd3, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      checks++; if (bus.ready !== 1'b0 || bus.done !== 1'b0) begin
        errors++; $display("FAIL uns_busy t+%0d: got ready=%b done=%b expected 0 0", k, bus.ready, bus.done);
      end
      tick();
    end
    checks++; if (bus.done !== 1'b1 || bus.ready !== 1'b1) begin errors++; $display("FAIL uns_done: got done=%b ready=%b expected 1 1", bus.done, bus.ready); end
    checks++; if (bus.quotient !== 4'd4) begin errors++; $display("FAIL uns_q: got %h expected 4", bus.quotient); end
    checks++; if (bus.remainder !== 4'd1) begin errors++; $display("FAIL uns_r: got %h expected 1", bus.remainder); end
    checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL uns_dz: got %b expected 0", bus.div_zero); end
    for (int k = 0; k < 3; k++) tick();
    checks++; if (bus.done !== 1'b1 || bus.quotient !== 4'd4 || bus.remainder !== 4'd1) begin
      errors++; $display("FAIL uns_hold: got done=%b q=%h r=%h expected 1 4 1", bus.done, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_signed();
    do_start(4'b1001, 4'd2, 1'b1);
    for (int k = 0; k < 5; k++) tick();
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL sgn_done: got %b expected 1", bus.done); end
    checks++; if (bus.quotient !== 4'b1101) begin errors++; $display("FAIL sgn_q: got %h expected d", bus.quotient); end
    checks++; if (bus.remainder !== 4'b1111) begin errors++; $display("FAIL sgn_r: got %h expected f", bus.remainder); end
    do_start(4'd7, 4'b1110, 1'b1);
    for (int k = 0; k < 5; k++) tick();
    checks++; if (bus.quotient !== 4'b1101 || bus.remainder !== 4'd1) begin
      errors++; $display("FAIL sgn_negdiv: got q=%h r=%h expected d 1", bus.quotient, bus.remainder);
    end
    do_start(4'b1001, 4'd2, 1'b0);
    for (int k = 0; k < 5; k++) tick();
    checks++; if (bus.quotient !== 4'd4 || bus.remainder !== 4'd1) begin
      errors++; $display("FAIL uns_msb: got q=%h r=%h expected 4 1", bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_div_zero();
    do_start(4'd9, 4'd0, 1'b0);
    checks++; if (bus.done !== 1'b1 || bus.ready !== 1'b1) begin errors++; $display("FAIL dz_done: got done=%b ready=%b expected 1 1", bus.done, bus.ready); end
    checks++; if (bus.div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b expected 1", bus.div_zero); end
    checks++; if (bus.quotient !== 4'hF) begin errors++; $display("FAIL dz_q: got %h expected f", bus.quotient); end
    checks++; if (bus.remainder !== 4'h9) begin errors++; $display("FAIL dz_r: got %h expected 9", bus.remainder); end
  endtask

  task automatic test_overflow();
    do_start(4'b1000, 4'b1111, 1'b1);
    for (int k = 0; k < 5; k++) tick();
    checks++; if (bus.done !== 1'b1 || bus.div_zero !== 1'b0) begin errors++; $display("FAIL ovf_done: got done=%b dz=%b expected 1 0", bus.done, bus.div_zero); end
    checks++; if (bus.quotient !== 4'b1000) begin errors++; $display("FAIL ovf_q: got %h expected 8", bus.quotient); end
    checks++; if (bus.remainder !== 4'd0) begin errors++; $display("FAIL ovf_r: got %h expected 0", bus.remainder); end
  endtask

  task automatic test_ignore_mid_calc();
    do_start(4'd13, 4'd3, 1'b0);
    tick();
    bus.src_a    = 4'd15;
    bus.src_b    = 4'd0;
    bus.d_signed = 1'b1;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    checks++; if (bus.ready !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL ign_busy: got ready=%b done=%b expected 0 0", bus.ready, bus.done); end
    for (int k = 0; k < 3; k++) tick();
    checks++; if (bus.done !== 1'b1 || bus.div_zero !== 1'b0) begin errors++; $display("FAIL ign_done: got done=%b dz=%b expected 1 0", bus.done, bus.div_zero); end
    checks++; if (bus.quotient !== 4'd4 || bus.remainder !== 4'd1) begin
      errors++; $display("FAIL ign_result: got q=%h r=%h expected 4 1", bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_back_to_back();
    do_start(4'd15, 4'd4, 1'b0);
    checks++; if (bus.done !== 1'b0 || bus.ready !== 1'b0) begin errors++; $display("FAIL b2b_drop: got done=%b ready=%b expected 0 0", bus.done, bus.ready); end
    for (int k = 0; k < 4; k++) tick();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL b2b_early: got done=%b expected 0", bus.done); end
    tick();
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b expected 1", bus.done); end
    checks++; if (bus.quotient !== 4'd3 || bus.remainder !== 4'd3) begin
      errors++; $display("FAIL b2b_result: got q=%h r=%h expected 3 3", bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_reset_mid();
    do_start(4'd13, 4'd3, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL rmid_state: got ready=%b done=%b expected 1 0", bus.ready, bus.done); end
    checks++; if (bus.quotient !== 4'd0 || bus.remainder !== 4'd0 || bus.div_zero !== 1'b0) begin
      errors++; $display("FAIL rmid_outs: got q=%h r=%h dz=%b expected 0 0 0", bus.quotient, bus.remainder, bus.div_zero);
    end
    do_start(4'd6, 4'd4, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rmid_early: got done=%b expected 0", bus.done); end
    tick();
    checks++; if (bus.done !== 1'b1 || bus.quotient !== 4'd1 || bus.remainder !== 4'd2) begin
      errors++; $display("FAIL rmid_result: got done=%b q=%h r=%h expected 1 1 2", bus.done, bus.quotient, bus.remainder);
    end
    bus.src_a = 4'd9;
    bus.src_b = 4'd0;
    bus.start = 1'b1;
    reset     = 1'b1;
    tick();
    bus.start = 1'b0;
    reset     = 1'b0;
    checks++; if (bus.done !== 1'b0 || bus.ready !== 1'b1 || bus.div_zero !== 1'b0) begin
      errors++; $display("FAIL rst_wins: got done=%b ready=%b dz=%b expected 0 1 0", bus.done, bus.ready, bus.div_zero);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.d_signed = 1'b0;
    bus.src_a    = 4'd0;
    bus.src_b    = 4'd0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_ignore_mid_calc();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
